// File: rtl/servo_cmd_if.sv
// servo_cmd_if -- byte stream handshake from a UART receiver into servo_cmd.
//   rx_data  : received byte
//   rx_valid : rx_data is valid
//   rx_ready : consumer can accept a byte (transfer when valid && ready on clk)
// Modports: master = byte source, slave = servo_cmd.
interface servo_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/servo_cmd.sv
// servo_cmd -- parses 3-byte angle frames (0xA5, A, ~A) and drives the duty and
// period values of a servo PWM stage, updating duty once per servo frame.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   rx         : byte stream handshake (servo_cmd_if.slave)
//   duty_cycle : PWM high time in clock cycles
//   period     : PWM counter terminal value (constant PERIOD_CYC-1)
//   angle      : last accepted angle, 0..180
//   frame_err  : one-cycle pulse on a rejected or timed-out frame
//
// Build option: define SERVO_SLEW_LIMIT_EN to limit the duty change per frame
// tick to SLEW_STEP cycles; otherwise duty jumps straight to the target.
module servo_cmd #(
  parameter int unsigned CLK_HZ     = 25000000,
  parameter int unsigned MIN_US     = 1000,
  parameter int unsigned MAX_US     = 2000,
  parameter int unsigned PERIOD_US  = 20000,
  parameter int unsigned SLEW_STEP  = 250,
  parameter int unsigned BYTE_TO_US = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  servo_cmd_if.slave         rx,
  output logic [31:0]        duty_cycle,
  output logic [31:0]        period,
  output logic [7:0]         angle,
  output logic               frame_err
);

  localparam int unsigned MHZ        = CLK_HZ / 1000000;
  localparam int unsigned MIN_CYC    = MHZ * MIN_US;
  localparam int unsigned MAX_CYC    = MHZ * MAX_US;
  localparam int unsigned STEP       = (MAX_CYC - MIN_CYC) / 180;
  localparam int unsigned PERIOD_CYC = MHZ * PERIOD_US;
  localparam int unsigned TO_CYC     = MHZ * BYTE_TO_US;
  localparam int unsigned MID_CYC    = MIN_CYC + 90 * STEP;
  localparam int unsigned SPAN       = 180 * STEP;

  // Without slew limiting, any limit covering the full duty span reduces the
  // shared stepping logic to a direct jump onto the target.
`ifdef SERVO_SLEW_LIMIT_EN
  localparam int unsigned STEP_LIM = SLEW_STEP;
`else
  localparam int unsigned STEP_LIM = (SLEW_STEP > SPAN) ? SLEW_STEP : SPAN;
`endif

  typedef enum logic [1:0] {IDLE, ANGLE, CHECK, APPLY} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        timeout;
  logic        err_set;
  logic        latch_a;
  logic        do_apply;
  logic [7:0]  a_q;
  logic [31:0] to_cnt;
  logic [31:0] tick_cnt;
  logic        tick;
  logic [31:0] target;
  logic [31:0] duty_next;

  assign rx.rx_ready = (state != APPLY);
  assign accept      = rx.rx_valid && rx.rx_ready;
  assign timeout     = (to_cnt == TO_CYC - 1);
  assign tick        = (tick_cnt == PERIOD_CYC - 1);
  assign period      = PERIOD_CYC - 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    latch_a    = 1'b0;
    do_apply   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && rx.rx_data == 8'hA5) state_next = ANGLE;
      end
      ANGLE: begin
        if (accept) begin
          latch_a    = 1'b1;
          state_next = CHECK;
        end else if (timeout) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      CHECK: begin
        if (accept) begin
          if (rx.rx_data == ~a_q && a_q <= 8'd180) begin
            state_next = APPLY;
          end else begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end else if (timeout) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      APPLY: begin
        do_apply   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Move duty toward target by at most STEP_LIM cycles.
  always_comb begin
    duty_next = target;
    if (target > duty_cycle) begin
      if (target - duty_cycle > STEP_LIM) duty_next = duty_cycle + STEP_LIM;
    end else if (duty_cycle - target > STEP_LIM) begin
      duty_next = duty_cycle - STEP_LIM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt     <= '0;
      tick_cnt   <= '0;
      a_q        <= '0;
      angle      <= 8'd90;
      target     <= MID_CYC;
      duty_cycle <= MID_CYC;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= err_set;
      tick_cnt  <= tick ? '0 : tick_cnt + 32'd1;

      // Inter-byte timer runs only while a frame is in progress.
      if (state == IDLE || accept) to_cnt <= '0;
      else if (state == ANGLE || state == CHECK) to_cnt <= to_cnt + 32'd1;

      if (latch_a) a_q <= rx.rx_data;

      if (do_apply) begin
        target <= MIN_CYC + {24'd0, a_q} * STEP;
        angle  <= a_q;
      end

      // duty sees the pre-APPLY target when both happen on the same edge.
      if (tick) duty_cycle <= duty_next;
    end
  end

endmodule

// File: tb/tb_servo_cmd.sv
// tb_servo_cmd -- directed self-checking bench for servo_cmd, run with scaled
// parameters (1 MHz clock, 100-cycle frame, 30-cycle byte timeout) so that many
// frame ticks fit in a short run. Derived: MIN=1000, STEP=5, MID=1450, MAX=1900.
module tb_servo_cmd;

  localparam int TB_PERIOD = 100;
  localparam int TB_SLEW   = 20;

  logic        clk;
  logic        rst_n;
  logic [31:0] duty_cycle;
  logic [31:0] period;
  logic [7:0]  angle;
  logic        frame_err;

  servo_cmd_if rx_bus ();

  servo_cmd #(
    .CLK_HZ    (1000000),
    .MIN_US    (1000),
    .MAX_US    (2000),
    .PERIOD_US (TB_PERIOD),
    .SLEW_STEP (TB_SLEW),
    .BYTE_TO_US(30)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_bus),
    .duty_cycle(duty_cycle),
    .period    (period),
    .angle     (angle),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;

  // Reference model of the frame-tick duty update.
  int          cyc;
  int          pend_cyc;
  logic [31:0] pend_target;
  logic [31:0] exp_target;
  logic [31:0] exp_duty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc        <= 0;
      exp_target <= 32'd1450;
      exp_duty   <= 32'd1450;
    end else begin
      cyc <= cyc + 1;
      if ((cyc + 1) % TB_PERIOD == 0) begin
`ifdef SERVO_SLEW_LIMIT_EN
        if (exp_target > exp_duty + TB_SLEW)      exp_duty <= exp_duty + TB_SLEW;
        else if (exp_duty > exp_target + TB_SLEW) exp_duty <= exp_duty - TB_SLEW;
        else                                      exp_duty <= exp_target;
`else
        exp_duty <= exp_target;
`endif
      end
      if (cyc + 1 == pend_cyc) exp_target <= pend_target;
    end
  end

  always @(negedge clk) if (frame_err) err_seen <= err_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; byte is presented across the next rising edge.
  task automatic send(input logic [7:0] b);
    rx_bus.rx_data  = b;
    rx_bus.rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send(b0);
    send(b1);
    send(b2);
    rx_bus.rx_valid = 1'b0;
  endtask

  // Expect APPLY on the next edge, loading the given target.
  task automatic expect_apply(input logic [31:0] tgt);
    pend_target = tgt;
    pend_cyc    = cyc + 1;
  endtask

  task automatic wait_tick(input string tag);
    do @(negedge clk); while (cyc % TB_PERIOD != 0);
    check(tag, duty_cycle, exp_duty);
  endtask

  int e0;
  int low_cnt;

  initial begin
    rst_n           = 1'b0;
    rx_bus.rx_data  = 8'h00;
    rx_bus.rx_valid = 1'b0;
    pend_cyc        = -1;
    pend_target     = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_ready", 32'(rx_bus.rx_ready), 32'd1);
    check("rst_angle", 32'(angle), 32'd90);
    check("rst_duty", duty_cycle, 32'd1450);
    check("rst_period", period, 32'd99);
    check("rst_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bad check byte
    e0 = err_seen;
    send_frame(8'hA5, 8'h10, 8'h10);
    repeat (3) @(negedge clk);
    check("badchk_err", 32'(err_seen - e0), 32'd1);
    check("badchk_angle", 32'(angle), 32'd90);
    wait_tick("badchk_duty");
    check("badchk_duty_lit", duty_cycle, 32'd1450);

    // Angle out of range
    e0 = err_seen;
    send_frame(8'hA5, 8'hC8, 8'h37);
    repeat (3) @(negedge clk);
    check("a200_err", 32'(err_seen - e0), 32'd1);
    check("a200_angle", 32'(angle), 32'd90);

    // Full-scale frame
    e0 = err_seen;
    send_frame(8'hA5, 8'hB4, 8'h4B);
    check("a180_apply_ready", 32'(rx_bus.rx_ready), 32'd0);
    expect_apply(32'd1900);
    @(negedge clk);
    check("a180_angle", 32'(angle), 32'd180);
    check("a180_ready", 32'(rx_bus.rx_ready), 32'd1);
    check("a180_noerr", 32'(err_seen - e0), 32'd0);
`ifdef SERVO_SLEW_LIMIT_EN
    for (int i = 0; i < 23; i++) wait_tick("a180_slew");
`else
    wait_tick("a180_duty");
`endif
    check("a180_duty_lit", duty_cycle, 32'd1900);

    // Inter-byte timeout after header
    send(8'hA5);
    rx_bus.rx_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("to_early", 32'(frame_err), 32'd0);
    @(negedge clk);
    check("to_pulse", 32'(frame_err), 32'd1);
    @(negedge clk);
    check("to_width", 32'(frame_err), 32'd0);
    send_frame(8'hA5, 8'h00, 8'hFF);
    expect_apply(32'd1000);
    @(negedge clk);
    check("a0_angle", 32'(angle), 32'd0);
    wait_tick("a0_duty");
`ifndef SERVO_SLEW_LIMIT_EN
    check("a0_duty_lit", duty_cycle, 32'd1000);
`endif

    // Continuous stream 00 A5 5A A5 with valid held high
    send(8'h00);
    send(8'hA5);
    send(8'h5A);
    send(8'hA5);
    expect_apply(32'd1450);
    rx_bus.rx_data = 8'h00;
    low_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (!rx_bus.rx_ready) low_cnt++;
      @(negedge clk);
    end
    rx_bus.rx_valid = 1'b0;
    check("stream_ready_low", 32'(low_cnt), 32'd1);
    check("stream_angle", 32'(angle), 32'd90);
    wait_tick("stream_duty");

    // APPLY on the tick edge: new target only from the following tick
    for (int i = 0; i < TB_PERIOD + 1 && (cyc % TB_PERIOD) != TB_PERIOD - 4; i++)
      @(negedge clk);
    send_frame(8'hA5, 8'hB4, 8'h4B);
    expect_apply(32'd1900);
    wait_tick("coinc_tick0");
`ifndef SERVO_SLEW_LIMIT_EN
    check("coinc_old_lit", duty_cycle, 32'd1450);
`endif
    check("coinc_angle", 32'(angle), 32'd180);
    wait_tick("coinc_tick1");
`ifndef SERVO_SLEW_LIMIT_EN
    check("coinc_new_lit", duty_cycle, 32'd1900);
`endif

    // Reset in the middle of a frame
    e0 = err_seen;
    send(8'hA5);
    send(8'hB4);
    rx_bus.rx_valid = 1'b0;
    rst_n    = 1'b0;
    pend_cyc = -1;
    @(negedge clk);
    check("midrst_angle", 32'(angle), 32'd90);
    check("midrst_duty", duty_cycle, 32'd1450);
    check("midrst_ready", 32'(rx_bus.rx_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h4B);
    rx_bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_noerr", 32'(err_seen - e0), 32'd0);
    check("midrst_angle2", 32'(angle), 32'd90);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/servo_cmd.md
SERVO_CMD -- requirements
Module: servo_cmd

Interface
REQ-001 Parameter CLK_HZ, default 25000000, clock frequency in Hz.
REQ-002 Parameter MIN_US, default 1000, pulse width for angle 0, in us.
REQ-003 Parameter MAX_US, default 2000, pulse width for angle 180, in us.
REQ-004 Parameter PERIOD_US, default 20000, servo frame period, in us.
REQ-005 Parameter SLEW_STEP, default 250, maximum duty change per frame tick, in clock cycles.
REQ-006 Parameter BYTE_TO_US, default 1000, inter-byte timeout within a frame, in us.
REQ-007 clk  input  1  system clock; all logic on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 rx_data  input  8  byte from the UART receiver.
REQ-010 rx_valid  input  1  rx_data valid; a byte is accepted when rx_valid and rx_ready are both high on a clk edge.
REQ-011 rx_ready  output  1  the block can accept a byte.
REQ-012 duty_cycle  output  32  high time in clock cycles, driven to the PWM stage.
REQ-013 period  output  32  PWM counter terminal value, driven to the PWM stage.
REQ-014 angle  output  8  last accepted angle, 0..180.
REQ-015 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-016 Derived constants shall be computed at elaboration by integer truncation: MIN_CYC=CLK_HZ/1e6*MIN_US; MAX_CYC likewise from MAX_US; STEP=(MAX_CYC-MIN_CYC)/180; PERIOD_CYC=CLK_HZ/1e6*PERIOD_US; TO_CYC=CLK_HZ/1e6*BYTE_TO_US.
REQ-017 period shall be the constant PERIOD_CYC-1 (499999 at defaults).
REQ-018 Frame format: header 0xA5, angle byte A, check byte equal to ~A.
REQ-019 FSM states: IDLE, ANGLE, CHECK, APPLY.
REQ-020 IDLE: an accepted 0xA5 moves the FSM to ANGLE; any other accepted byte is discarded silently.
REQ-021 ANGLE: any accepted byte, including 0xA5, is latched as A and the FSM moves to CHECK.
REQ-022 CHECK: if the accepted byte equals ~A and A<=180, the FSM moves to APPLY; otherwise frame_err pulses for one cycle, the target is unchanged, and the FSM returns to IDLE.
REQ-023 APPLY lasts exactly one cycle, with rx_ready low; it sets target=MIN_CYC+A*STEP and angle=A, then returns to IDLE.
REQ-024 rx_ready shall be high in IDLE, ANGLE and CHECK.
REQ-025 In ANGLE or CHECK, TO_CYC cycles without an accepted byte shall pulse frame_err and return the FSM to IDLE; the timeout counter restarts on every accepted byte.
REQ-026 A free-running tick counter shall count 0..PERIOD_CYC-1 and wrap; duty_cycle shall change only on the cycle after the counter reaches PERIOD_CYC-1.
REQ-027 A new target arriving while duty_cycle is moving toward an earlier target shall retarget immediately; no frame is queued.
REQ-028 A target set on the same cycle as a tick shall be used from the next tick.
REQ-029 duty_cycle shall never leave the range MIN_CYC..MIN_CYC+180*STEP.

Reset
REQ-030 While rst_n is low: FSM=IDLE, counters=0, frame_err=0, angle=90, target=duty_cycle=MIN_CYC+90*STEP (37420 at defaults), period=PERIOD_CYC-1, rx_ready=1.
REQ-031 Assertion of rst_n mid-frame shall abandon the partial frame with no frame_err pulse.

Configuration
REQ-032 Macro SERVO_SLEW_LIMIT_EN defined: at each tick duty_cycle moves toward target by min(|target-duty_cycle|, SLEW_STEP).
REQ-033 Macro SERVO_SLEW_LIMIT_EN undefined: at each tick duty_cycle is set equal to target.

Verification
REQ-034 After reset, bytes A5 B4 4B -> angle=180 one cycle after the third byte; with the macro off, duty_cycle=49840 after the next tick.
REQ-035 Macro on, from reset, frame A5 B4 4B -> duty_cycle rises by 250 per tick and reaches 49840 on the 50th tick, never overshooting.
REQ-036 Bytes A5 10 10 -> frame_err pulses for exactly 1 cycle; angle and duty_cycle are unchanged.
REQ-037 Bytes A5 C8 37 (angle 200) -> frame_err pulses; angle stays 90.
REQ-038 A5 then a 25001-cycle gap -> frame_err pulses at the timeout; a following A5 00 FF frame gives angle=0 and duty_cycle=25000 (macro off).
REQ-039 rx_valid held high with the stream 00 A5 5A A5 -> rx_ready is low for exactly one cycle after the last byte; angle=90; the leading 00 is ignored.
